// File: rtl/set_counter_n_if.sv
// rtl/set_counter_n_if.sv - command/result bundle between host and the set counter engine
interface set_counter_n_if #(
    parameter int GRID  = 8,
    parameter int NCIRC = 3,
    parameter int CW    = 4,
    parameter int RW    = 4,
    parameter int CNTW  = $clog2(GRID*GRID+1)
);
    logic                    en;
    logic [2*NCIRC*CW-1:0]   central;
    logic [NCIRC*RW-1:0]     radius;
    logic [2:0]              mode;
    logic                    busy;
    logic                    valid;
    logic [CNTW-1:0]         candidate;

    modport master (
        output en, central, radius, mode,
        input  busy, valid, candidate
    );

    modport slave (
        input  en, central, radius, mode,
        output busy, valid, candidate
    );
endinterface

// File: rtl/set_counter_n.sv
// rtl/set_counter_n.sv - lattice-point counter over a set expression of NCIRC circles
module set_counter_n #(
    parameter int GRID  = 8,
    parameter int NCIRC = 3,
    parameter int CW    = 4,
    parameter int RW    = 4,
    parameter int CNTW  = $clog2(GRID*GRID+1)
) (
    input  logic            clk,
    input  logic            rst,
    set_counter_n_if.slave  bus
);
    localparam int SQW  = 2*CW + 2;
    localparam int SUMW = SQW + 1;
    localparam int R2W  = 2*RW;
    localparam int CMPW = (SUMW > R2W) ? SUMW : R2W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]          x, y;
    logic [2*NCIRC*CW-1:0]  job_central;
    logic [NCIRC*RW-1:0]    job_radius;
    logic [2:0]             job_mode;
    logic [CNTW-1:0]        count;

    logic                   accept;
    logic                   last_point;
    logic                   y_wrap;
    logic [NCIRC-1:0]       in_circ;
    logic [2:0]             k;
    logic                   hit;

    assign y_wrap     = (y == CW'(GRID));
    assign last_point = (x == CW'(GRID)) && y_wrap;

    // Membership uses the magnitude of each delta so squares stay unsigned and exact.
    for (genvar i = 0; i < NCIRC; i++) begin : g_circ
        logic [CW-1:0]          cx, cy;
        logic [RW-1:0]          r;
        logic signed [CW+1:0]   dx, dy, ndx, ndy;
        logic [CW:0]            ax, ay;
        logic [SQW-1:0]         sx, sy;
        logic [SUMW-1:0]        sum;
        logic [R2W-1:0]         r2;

        assign cx  = job_central[2*i*CW +: CW];
        assign cy  = job_central[(2*i+1)*CW +: CW];
        assign r   = job_radius[i*RW +: RW];

        assign dx  = $signed({2'b00, x}) - $signed({2'b00, cx});
        assign dy  = $signed({2'b00, y}) - $signed({2'b00, cy});
        assign ndx = -dx;
        assign ndy = -dy;
        assign ax  = dx[CW+1] ? ndx[CW:0] : dx[CW:0];
        assign ay  = dy[CW+1] ? ndy[CW:0] : dy[CW:0];

        assign sx  = SQW'(ax) * SQW'(ax);
        assign sy  = SQW'(ay) * SQW'(ay);
        assign sum = SUMW'(sx) + SUMW'(sy);
        assign r2  = R2W'(r) * R2W'(r);

        assign in_circ[i] = (CMPW'(sum) <= CMPW'(r2));
    end

    always_comb begin
        k = 3'd0;
        for (int i = 0; i < NCIRC; i++) begin
            k = k + 3'(in_circ[i]);
        end
    end

    always_comb begin
        hit = 1'b0;
        unique case (job_mode)
            3'b000:  hit = in_circ[0];
            3'b001:  hit = &in_circ;
            3'b010:  hit = (k == 3'd1);
            3'b011:  hit = (k >= 3'd1);
            3'b100:  hit = (k >= 3'd2);
            3'b101:  hit = ^in_circ;
            default: hit = 1'b0;
        endcase
    end

    // A new command is taken in IDLE and also in DONE, which allows back-to-back jobs.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.en) begin
                    accept   = 1'b1;
                    state_nx = S_SCAN;
                end
            end
            S_SCAN: begin
                if (last_point) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.en) begin
                    accept   = 1'b1;
                    state_nx = S_SCAN;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x           <= CW'(1);
            y           <= CW'(1);
            count       <= '0;
            job_central <= '0;
            job_radius  <= '0;
            job_mode    <= 3'b000;
        end else if (accept) begin
            x           <= CW'(1);
            y           <= CW'(1);
            count       <= '0;
            job_central <= bus.central;
            job_radius  <= bus.radius;
            job_mode    <= bus.mode;
        end else if (state == S_SCAN) begin
            count <= count + CNTW'(hit);
            if (last_point) begin
                x <= CW'(1);
                y <= CW'(1);
            end else if (y_wrap) begin
                y <= CW'(1);
                x <= x + CW'(1);
            end else begin
                y <= y + CW'(1);
            end
        end
    end

    assign bus.busy      = (state == S_SCAN);
    assign bus.valid     = (state == S_DONE);
    assign bus.candidate = count;
endmodule

// File: tb/tb_set_counter_n.sv
// tb/tb_set_counter_n.sv - scoreboard bench for set_counter_n with directed jobs
module tb_set_counter_n;
    localparam int LAT = 65;

    logic clk = 1'b0;
    logic rst = 1'b0;

    set_counter_n_if bus ();

    set_counter_n dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int exp;
        int issue;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    fails  = 0;
    int    ncyc   = 0;
    int    nvalid = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] pk(input int x0, input int y0, input int x1,
                                       input int y1, input int x2, input int y2);
        return {4'(y2), 4'(x2), 4'(y1), 4'(x1), 4'(y0), 4'(x0)};
    endfunction

    function automatic logic [11:0] rk(input int r0, input int r1, input int r2);
        return {4'(r2), 4'(r1), 4'(r0)};
    endfunction

    // Monitor: pops one expectation per valid strobe
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            ncyc++;
            if (bus.valid === 1'b1) begin
                nvalid++;
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_valid: got valid=1 expected no pending job (t=%0t)", $time);
                end else begin
                    it = sb.pop_front();
                    check("candidate", int'(bus.candidate), it.exp);
                    check("latency", ncyc - it.issue, LAT);
                    check("busy_at_valid", int'(bus.busy), 0);
                end
            end
        end
    end

    task automatic issue(input logic [23:0] c, input logic [11:0] r, input logic [2:0] m,
                         input int exp);
        item_t it;
        bus.central = c;
        bus.radius  = r;
        bus.mode    = m;
        bus.en      = 1'b1;
        it.exp      = exp;
        it.issue    = ncyc;
        sb.push_back(it);
        @(negedge clk);
        #1;
        bus.en = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (bus.valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL valid_timeout: got no valid after %0d cycles expected valid", n);
        end
    endtask

    task automatic run_job(input logic [23:0] c, input logic [11:0] r, input logic [2:0] m,
                           input int exp);
        issue(c, r, m, exp);
        wait_valid();
        @(negedge clk);
        #1;
        check("valid_drop", int'(bus.valid), 0);
        check("candidate_hold", int'(bus.candidate), exp);
    endtask

    initial begin
        int v0;
        bus.en      = 1'b0;
        bus.central = '0;
        bus.radius  = '0;
        bus.mode    = 3'b000;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_valid", int'(bus.valid), 0);
        check("reset_candidate", int'(bus.candidate), 0);
        rst = 1'b1;
        @(negedge clk);
        #1;

        // single circle, growing radius, and off-grid / far centres
        run_job(pk(4, 4, 0, 0, 0, 0), rk(0, 0, 0), 3'b000, 1);
        run_job(pk(4, 4, 0, 0, 0, 0), rk(1, 0, 0), 3'b000, 5);
        run_job(pk(4, 4, 0, 0, 0, 0), rk(2, 0, 0), 3'b000, 13);
        run_job(pk(0, 0, 0, 0, 0, 0), rk(2, 0, 0), 3'b000, 1);
        run_job(pk(0, 0, 0, 0, 0, 0), rk(15, 0, 0), 3'b000, 64);
        run_job(pk(15, 15, 0, 0, 0, 0), rk(15, 0, 0), 3'b000, 32);

        // set operations
        run_job(pk(4, 4, 4, 4, 4, 4), rk(2, 1, 15), 3'b001, 5);
        run_job(pk(4, 4, 0, 0, 0, 0), rk(15, 0, 0), 3'b011, 64);
        run_job(pk(4, 4, 4, 4, 15, 15), rk(1, 2, 0), 3'b010, 8);
        run_job(pk(4, 4, 4, 4, 15, 15), rk(1, 2, 0), 3'b100, 5);
        run_job(pk(4, 4, 4, 4, 15, 15), rk(1, 2, 0), 3'b101, 8);
        run_job(pk(4, 4, 4, 4, 4, 4), rk(15, 15, 15), 3'b111, 0);
        run_job(pk(4, 4, 4, 4, 4, 4), rk(15, 15, 15), 3'b110, 0);

        // inputs and en churn while busy
        issue(pk(4, 4, 0, 0, 0, 0), rk(2, 0, 0), 3'b000, 13);
        for (int i = 0; i < 20; i++) begin
            bus.central = 24'($urandom);
            bus.radius  = 12'($urandom);
            bus.mode    = 3'($urandom);
            bus.en      = 1'($urandom);
            @(negedge clk);
            #1;
        end
        bus.en = 1'b0;
        wait_valid();

        // back-to-back: second command in the valid cycle
        issue(pk(4, 4, 4, 4, 15, 15), rk(1, 2, 0), 3'b101, 8);
        check("b2b_busy", int'(bus.busy), 1);
        wait_valid();
        @(negedge clk);
        #1;
        check("b2b_valid_drop", int'(bus.valid), 0);

        // reset in mid-scan aborts the job with no result
        issue(pk(4, 4, 0, 0, 0, 0), rk(15, 0, 0), 3'b000, 64);
        repeat (28) begin
            @(negedge clk);
            #1;
        end
        check("pre_reset_busy", int'(bus.busy), 1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_valid", int'(bus.valid), 0);
        check("abort_candidate", int'(bus.candidate), 0);
        sb.delete();
        v0 = nvalid;
        repeat (80) begin
            @(negedge clk);
            #1;
        end
        check("no_valid_after_abort", nvalid - v0, 0);
        run_job(pk(4, 4, 0, 0, 0, 0), rk(1, 0, 0), 3'b000, 5);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/set_counter_n.md
# set_counter_n

Parametrised lattice-point set counter, successor to the two-circle SET engine. It accepts NCIRC circles (centre and radius) and a 3-bit set-operation mode. It then scans every integer point (x,y), 1..GRID on each axis, one point per clock, and counts the points that satisfy the selected membership rule. It sits beside the host as a busy/valid command engine, with one job in flight at a time.

## Interface
Parameters:
- GRID, default 8: grid edge; points x,y ∈ 1..GRID (GRID ≤ 2^CW − 1).
- NCIRC, default 3: number of circles, legal 1..4.
- CW, default 4: centre coordinate width, unsigned.
- RW, default 4: radius width, unsigned.
- CNTW, default $clog2(GRID*GRID+1): candidate width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  command strobe; sampled only when busy=0.
- central  in  2*NCIRC*CW  circle i: x = central[2*i*CW +: CW], y = central[(2*i+1)*CW +: CW].
- radius  in  NCIRC*RW  circle i radius = radius[i*RW +: RW].
- mode  in  3  set operation, see Operation.
- busy  out  1  scan in progress.
- valid  out  1  one-cycle result strobe.
- candidate  out  CNTW  point count; final when valid=1.

## Operation
- Reset (rst=0 at a clock edge): busy=0, valid=0, candidate=0, scan x=y=1. This applies at any time, including mid-scan. The job is aborted and no valid is issued.
- IDLE (busy=0): en=1 registers central, radius and mode, clears candidate to 0, sets busy=1 and sets the scan to (1,1). With en=0, candidate holds its last value.
- SCAN (busy=1): each cycle evaluates the current point, adds 1 to candidate if the rule holds, and advances the scan. y increments first. At y=GRID, y returns to 1 and x increments.
- After point (GRID,GRID) is counted, the next cycle is DONE.
- DONE: valid=1 and busy=0 in the same cycle, with the final count on candidate. valid drops the following cycle. candidate holds until the next accepted en.
- en while busy=1 is ignored and does not affect the job. Input changes after acceptance are ignored.
- Membership of circle i: (x−cx_i)² + (y−cy_i)² ≤ r_i².
  - Deltas are signed CW+2 bits.
  - Squares are unsigned 2*CW+2 bits. The sum is one bit wider.
  - r² is 2*RW bits, zero-extended for the compare.
  - No truncation is allowed anywhere in this path.
- Let in[i] be the membership of circle i and k = popcount(in):
  - 000: in[0] only.
  - 001: all circles (AND).
  - 010: exactly one (k==1).
  - 011: union (k≥1).
  - 100: at least two (k≥2).
  - 101: odd parity (XOR).
  - 110, 111: reserved. These scan with normal timing and always return candidate=0.
- Boundary cases:
  - r=0 counts only the centre, if the centre is on the grid.
  - Centres outside 1..GRID, including 0 and 15, are legal.
  - A full-grid count of GRID² must fit in CNTW bits with no wrap.

## Timing
- Cycle T: en accepted.
- Cycles T+1 … T+GRID²: busy=1, one point evaluated per cycle.
- Cycle T+GRID²+1: valid=1, busy=0.
- Total latency from en to valid is GRID²+1 cycles. For GRID=8 this is 65.
- Back-to-back: en=1 during the valid cycle is accepted. The next job's busy rises in the following cycle. The result of the previous job is still presented for its full valid cycle.
- The membership path is combinational from registered job state and the scan counters. candidate is registered.

## Test plan
Defaults throughout: GRID=8, NCIRC=3.
- Mode 000, circle0 (4,4): r=0 → 1, r=1 → 5, r=2 → 13. valid must rise exactly 65 cycles after en.
- Mode 001, circles (4,4) r=2, (4,4) r=1, (4,4) r=15 → 5. Mode 011 with circle0 (4,4) r=15 → 64.
- Mode 010, circles (4,4) r=1, (4,4) r=2, (15,15) r=0 → 8. Mode 100 with the same circles → 5. Mode 101 with the same circles → 8.
- Mode 111 with any inputs → candidate=0, with valid at cycle 65.
- Inputs and en toggled while busy → no effect on the count. en asserted in the valid cycle → second job starts, busy high the next cycle, and its result is correct.
- rst=0 held one cycle at scan cycle 30 → busy=0, valid=0, candidate=0 on the next edge. No valid follows. A subsequent job is correct.
